mem_wb_register: RTL and testbench
==================================

Name: mem_wb_register

Overview:
MEM/WB pipeline register of the MIPS core. It sits between the data-memory access and the write-back data mux, and registers everything that mux and the register-file write port consume. It also performs load-data alignment and sign/zero extension, and selects between the ALU result and the loaded data. It supports stall, flush, a sticky HALT state and a retired-instruction counter for the debug unit.

Parameters:
NBITS, 32, datapath width
NREG_BITS, 5, register-file address width
CNT_BITS, 32, retired-instruction counter width

Ports:
i_clk  in  1  core clock
i_reset  in  1  synchronous, active-high reset
i_stall  in  1  hold all state this cycle
i_flush  in  1  insert bubble this cycle
i_valid  in  1  MEM stage holds a real instruction
i_alu_result  in  NBITS  ALU result / effective address
i_mem_rdata  in  NBITS  raw aligned word from data memory
i_pc_8  in  NBITS  PC+8 of the instruction
i_rd_addr  in  NREG_BITS  destination register
i_reg_write  in  1  instruction writes the register file
i_mem_to_reg  in  1  1 = load data, 0 = ALU result
i_load_size  in  2  00 byte, 01 half, 11 word (10 treated as word)
i_load_unsigned  in  1  zero-extend (LBU/LHU)
i_jal  in  1  link instruction
i_halt  in  1  HALT instruction
o_mem_data  out  NBITS  selected write-back data (not PC+8)
o_pc_8  out  NBITS  registered PC+8
o_jal  out  1  registered link select
o_rd_addr  out  NREG_BITS  registered destination
o_reg_write  out  1  qualified write enable
o_valid  out  1  stage holds a real instruction
o_misaligned  out  1  one-cycle flag: misaligned load retired
o_halt  out  1  sticky halted indication
o_retired  out  CNT_BITS  retired-instruction count

Behaviour:
- Every output resets to 0, and the FSM resets to RUN. Latency is 1 cycle, input to output.
- Per-edge priority: i_reset > i_stall > i_flush > capture.
- Stall: every register holds, including the counter, FSM and o_misaligned. Stall together with flush still holds; the flush is dropped.
- Flush, or capture with i_valid=0: a bubble. o_valid, o_reg_write, o_jal and o_misaligned go to 0. Data and address registers may hold any value.
- Capture with i_valid=1 in RUN: all fields are registered, and o_retired increments by 1, wrapping from all-ones to 0.
- Load extraction uses offset = i_alu_result[1:0] and little-endian lanes:
  - byte: lane = offset; bits [8*offset+7 : 8*offset].
  - half: i_alu_result[1] selects the upper half.
  - word: the whole word.
  - Extension is sign unless i_load_unsigned; word is never extended.
- Misalignment applies only when i_mem_to_reg=1: half with offset[0]=1, or word with offset≠0. A misaligned load retires with o_misaligned=1 for one cycle, o_reg_write=0, and o_mem_data holding the unaligned raw word. It still counts as retired.
- o_mem_data = extracted load data if i_mem_to_reg, else i_alu_result.
- o_reg_write = i_reg_write & i_valid & (i_rd_addr≠0) & ~misaligned. JAL to $31 is not masked.
- FSM:
  - RUN→HALTED when a valid i_halt is captured. That HALT instruction itself appears with o_valid=1, counts as retired and writes nothing.
  - HALTED: o_halt=1. Every capture becomes a bubble, and the counter freezes.
  - HALTED exits only via i_reset.
- Reset during a stall or in HALTED clears everything on that edge.

Decomposition:
- Shared package: load-size encodings (LS_BYTE=2'b00, LS_HALF=2'b01, LS_WORD=2'b11) and FSM state encodings (ST_RUN, ST_HALTED). The core's other stages reuse both.
- One sub-module is natural: load_align_ext, combinational. Inputs are raw word, offset, size and unsigned; outputs are extended data and misaligned.
- The register/FSM/counter logic stays in mem_wb_register.

Test Plan:
- LB, addr offset 2, i_mem_rdata=0x1280_FF34 → next cycle o_mem_data=0xFFFF_FF80, o_reg_write=1, o_retired=1. LBU with the same inputs → 0x0000_0080.
- LH, offset 2, rdata=0x8001_0000 → 0xFFFF_8001. LH at offset 1 → o_misaligned=1 for one cycle, o_reg_write=0, counter still increments.
- ALU op (i_mem_to_reg=0), i_alu_result=0xDEAD_BEEF, rd=0, reg_write=1 → o_mem_data=0xDEAD_BEEF, o_reg_write=0 ($0 masked).
- JAL, i_pc_8=0x0000_0048, rd=31 → o_jal=1, o_pc_8=0x48, o_reg_write=1. Next, stall for 3 cycles with changing inputs → outputs unchanged. Stall with flush together → still held.
- Flush with i_valid=1 → o_valid=0, o_reg_write=0, counter unchanged.
- Valid HALT → o_valid=1 and o_halt=1 on the same edge. Three further valid instructions → o_valid=0 and o_retired frozen. Then i_reset=1 → all outputs 0, back in RUN.

Source files
------------

// File: rtl/mem_wb_register_pkg.sv
// Shared encodings for the MEM/WB boundary: load sizes, stage FSM states and
// the load misalignment rule, reused by the other pipeline stages.
package mem_wb_register_pkg;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_RSVD = 2'b10;
  localparam logic [1:0] LS_WORD = 2'b11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // The reserved size code behaves as a word access, so it must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (size)
      LS_BYTE: mis = 1'b0;
      LS_HALF: mis = offset[0];
      default: mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_wb_register_load_align_ext.sv
// Combinational load-data lane extraction and sign/zero extension.
// A misaligned access passes the raw word through untouched.
module load_align_ext
  import mem_wb_register_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic [NBITS-1:0] i_raw,
  input  logic [1:0]       i_offset,
  input  logic [1:0]       i_size,
  input  logic             i_unsigned,
  output logic [NBITS-1:0] o_data,
  output logic             o_misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (i_offset)
      2'd0: byte_sel = i_raw[7:0];
      2'd1: byte_sel = i_raw[15:8];
      2'd2: byte_sel = i_raw[23:16];
      2'd3: byte_sel = i_raw[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  assign half_sel = i_offset[1] ? i_raw[31:16] : i_raw[15:0];

  always_comb begin
    o_misaligned = is_misaligned(i_size, i_offset);
    o_data       = i_raw;
    case (i_size)
      LS_BYTE: begin
        if (i_unsigned) o_data = {{(NBITS-8){1'b0}}, byte_sel};
        else            o_data = {{(NBITS-8){byte_sel[7]}}, byte_sel};
      end
      LS_HALF: begin
        if (i_unsigned) o_data = {{(NBITS-16){1'b0}}, half_sel};
        else            o_data = {{(NBITS-16){half_sel[15]}}, half_sel};
      end
      default: o_data = i_raw;
    endcase
    if (o_misaligned) o_data = i_raw;
  end

endmodule

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: load alignment, write-back data select, stall/flush,
// sticky HALT state and retired-instruction counter.
module mem_wb_register
  import mem_wb_register_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int NREG_BITS = 5,
  parameter int CNT_BITS  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [NBITS-1:0]     i_alu_result,
  input  logic [NBITS-1:0]     i_mem_rdata,
  input  logic [NBITS-1:0]     i_pc_8,
  input  logic [NREG_BITS-1:0] i_rd_addr,
  input  logic                 i_reg_write,
  input  logic                 i_mem_to_reg,
  input  logic [1:0]           i_load_size,
  input  logic                 i_load_unsigned,
  input  logic                 i_jal,
  input  logic                 i_halt,
  output logic [NBITS-1:0]     o_mem_data,
  output logic [NBITS-1:0]     o_pc_8,
  output logic                 o_jal,
  output logic [NREG_BITS-1:0] o_rd_addr,
  output logic                 o_reg_write,
  output logic                 o_valid,
  output logic                 o_misaligned,
  output logic                 o_halt,
  output logic [CNT_BITS-1:0]  o_retired,
  output state_e               o_state
);

  state_e               state_q, state_d;
  logic [NBITS-1:0]     mem_data_q, mem_data_d;
  logic [NBITS-1:0]     pc_8_q, pc_8_d;
  logic                 jal_q, jal_d;
  logic [NREG_BITS-1:0] rd_q, rd_d;
  logic                 reg_write_q, reg_write_d;
  logic                 valid_q, valid_d;
  logic                 mis_q, mis_d;
  logic [CNT_BITS-1:0]  retired_q, retired_d;

  logic [NBITS-1:0] load_data;
  logic             align_mis;
  logic             load_mis;
  logic             capture;

  load_align_ext #(
    .NBITS(NBITS)
  ) u_align (
    .i_raw        (i_mem_rdata),
    .i_offset     (i_alu_result[1:0]),
    .i_size       (i_load_size),
    .i_unsigned   (i_load_unsigned),
    .o_data       (load_data),
    .o_misaligned (align_mis)
  );

  // Only loads can be misaligned; ALU results carry arbitrary low bits.
  assign load_mis = i_mem_to_reg & align_mis;
  assign capture  = ~i_stall & ~i_flush & i_valid & (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    mem_data_d  = mem_data_q;
    pc_8_d      = pc_8_q;
    jal_d       = jal_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    valid_d     = valid_q;
    mis_d       = mis_q;
    retired_d   = retired_q;
    if (!i_stall) begin
      // Bubble by default; data/address fields keep their old contents.
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      jal_d       = 1'b0;
      mis_d       = 1'b0;
      if (capture) begin
        mem_data_d  = i_mem_to_reg ? load_data : i_alu_result;
        pc_8_d      = i_pc_8;
        jal_d       = i_jal;
        rd_d        = i_rd_addr;
        reg_write_d = i_reg_write & (i_rd_addr != '0) & ~load_mis;
        valid_d     = 1'b1;
        mis_d       = load_mis;
        retired_d   = retired_q + CNT_BITS'(1);
        if (i_halt) state_d = ST_HALTED;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_RUN;
      mem_data_q  <= '0;
      pc_8_q      <= '0;
      jal_q       <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
      mis_q       <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_data_q  <= mem_data_d;
      pc_8_q      <= pc_8_d;
      jal_q       <= jal_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      valid_q     <= valid_d;
      mis_q       <= mis_d;
      retired_q   <= retired_d;
    end
  end

  assign o_mem_data   = mem_data_q;
  assign o_pc_8       = pc_8_q;
  assign o_jal        = jal_q;
  assign o_rd_addr    = rd_q;
  assign o_reg_write  = reg_write_q;
  assign o_valid      = valid_q;
  assign o_misaligned = mis_q;
  assign o_halt       = (state_q == ST_HALTED);
  assign o_retired    = retired_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_mem_wb_register.sv
// Directed plus random bench for mem_wb_register with an expected-output queue.
module tb_mem_wb_register;
  import mem_wb_register_pkg::*;

  typedef struct packed {
    logic [31:0] mem_data;
    logic [31:0] pc_8;
    logic        jal;
    logic [4:0]  rd;
    logic        reg_write;
    logic        valid;
    logic        mis;
    logic        halt;
    logic [31:0] retired;
    logic        data_known;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic        clk;
  logic        reset, stall, flush, valid;
  logic [31:0] alu, rdata, pc8;
  logic [4:0]  rd;
  logic        rw, m2r, luns, jal, halt;
  logic [1:0]  lsize;

  logic [31:0] o_mem_data, o_pc_8, o_retired;
  logic        o_jal, o_reg_write, o_valid, o_misaligned, o_halt;
  logic [4:0]  o_rd_addr;
  state_e      o_state;

  logic [EW-1:0] exp_q[$];
  exp_t          m;
  int            total = 0;
  int            bad = 0;

  mem_wb_register dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_flush(flush), .i_valid(valid),
    .i_alu_result(alu), .i_mem_rdata(rdata), .i_pc_8(pc8), .i_rd_addr(rd),
    .i_reg_write(rw), .i_mem_to_reg(m2r), .i_load_size(lsize),
    .i_load_unsigned(luns), .i_jal(jal), .i_halt(halt),
    .o_mem_data(o_mem_data), .o_pc_8(o_pc_8), .o_jal(o_jal), .o_rd_addr(o_rd_addr),
    .o_reg_write(o_reg_write), .o_valid(o_valid), .o_misaligned(o_misaligned),
    .o_halt(o_halt), .o_retired(o_retired), .o_state(o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input exp_t c);
    exp_t        n;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld;
    logic [1:0]  off;
    logic        mis;
    n = c;
    if (reset) begin
      n = '0;
      n.data_known = 1'b1;
      return n;
    end
    if (stall) return c;
    n.valid = 1'b0; n.reg_write = 1'b0; n.jal = 1'b0; n.mis = 1'b0;
    if (flush || !valid || c.halt) begin
      n.data_known = 1'b0;
      return n;
    end
    off = alu[1:0];
    b = 8'(rdata >> (8 * off));
    h = 16'(rdata >> (off[1] ? 16 : 0));
    if (lsize == 2'b00) begin
      ld  = luns ? {24'b0, b} : {{24{b[7]}}, b};
      mis = 1'b0;
    end else if (lsize == 2'b01) begin
      ld  = luns ? {16'b0, h} : {{16{h[15]}}, h};
      mis = off[0];
    end else begin
      ld  = rdata;
      mis = (off != 2'b00);
    end
    mis = mis & m2r;
    n.mem_data   = !m2r ? alu : (mis ? rdata : ld);
    n.pc_8       = pc8;
    n.jal        = jal;
    n.rd         = rd;
    n.reg_write  = rw && (rd != 5'd0) && !mis;
    n.valid      = 1'b1;
    n.mis        = mis;
    n.retired    = c.retired + 32'd1;
    n.data_known = 1'b1;
    if (halt) n.halt = 1'b1;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".valid"}, 32'(o_valid), 32'(e.valid));
    chk({tag, ".reg_write"}, 32'(o_reg_write), 32'(e.reg_write));
    chk({tag, ".jal"}, 32'(o_jal), 32'(e.jal));
    chk({tag, ".mis"}, 32'(o_misaligned), 32'(e.mis));
    chk({tag, ".halt"}, 32'(o_halt), 32'(e.halt));
    chk({tag, ".state"}, 32'(o_state), 32'(e.halt));
    chk({tag, ".retired"}, o_retired, e.retired);
    if (e.data_known) begin
      chk({tag, ".mem_data"}, o_mem_data, e.mem_data);
      chk({tag, ".pc_8"}, o_pc_8, e.pc_8);
      chk({tag, ".rd"}, 32'(o_rd_addr), 32'(e.rd));
    end
  endtask

  task automatic cyc(input string tag);
    exp_t e;
    e = model(m);
    m = e;
    exp_q.push_back(EW'(e));
    @(posedge clk);
    #1;
    e = exp_t'(exp_q.pop_front());
    check_outputs(tag, e);
  endtask

  task automatic set_instr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input logic u, input logic to_reg, input logic [4:0] r,
                           input logic w, input logic j, input logic [31:0] p);
    valid = 1'b1; alu = a; rdata = d; lsize = sz; luns = u; m2r = to_reg;
    rd = r; rw = w; jal = j; pc8 = p; halt = 1'b0;
  endtask

  task automatic rand_instr();
    set_instr($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
  endtask

  initial begin
    m = '0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_instr(32'h0, 32'h0, LS_WORD, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    valid = 1'b0;
    cyc("reset");
    chk("reset_retired", o_retired, 32'h0);
    reset = 1'b0;

    set_instr(32'h0000_1002, 32'h1280_FF34, LS_BYTE, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 32'h10);
    cyc("lb");
    chk("lb_const", o_mem_data, 32'hFFFF_FF80);
    chk("lb_count", o_retired, 32'd1);
    luns = 1'b1;
    cyc("lbu");
    chk("lbu_const", o_mem_data, 32'h0000_0080);

    set_instr(32'h0000_2002, 32'h8001_0000, LS_HALF, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 32'h14);
    cyc("lh");
    chk("lh_const", o_mem_data, 32'hFFFF_8001);
    alu = 32'h0000_2001;
    cyc("lh_mis");
    chk("lh_mis_flag", 32'(o_misaligned), 32'd1);

    set_instr(32'hDEAD_BEEF, 32'h0, LS_WORD, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h18);
    cyc("alu_r0");
    chk("alu_const", o_mem_data, 32'hDEAD_BEEF);

    set_instr(32'h0000_0003, 32'hCAFE_F00D, LS_WORD, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 32'h1C);
    cyc("lw_mis");
    for (int off = 0; off < 4; off++) begin
      set_instr(32'(off), 32'h89AB_CDEF, LS_BYTE, 1'($urandom_range(0, 1)), 1'b1,
                5'd9, 1'b1, 1'b0, 32'h20);
      cyc("lb_lane");
    end

    set_instr(32'h0, 32'h0, LS_WORD, 1'b0, 1'b0, 5'd31, 1'b1, 1'b1, 32'h0000_0048);
    cyc("jal");
    chk("jal_pc8", o_pc_8, 32'h48);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_instr();
      cyc("stall");
    end
    flush = 1'b1;
    cyc("stall_flush");
    stall = 1'b0;
    rand_instr();
    cyc("flush");
    flush = 1'b0;

    for (int i = 0; i < 12; i++) begin
      rand_instr();
      if (i % 4 == 3) valid = 1'b0;
      cyc("rand");
    end

    rand_instr();
    stall = 1'b1; reset = 1'b1;
    cyc("reset_in_stall");
    stall = 1'b0; reset = 1'b0;

    set_instr(32'h0, 32'h0, LS_WORD, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h80);
    halt = 1'b1;
    cyc("halt");
    chk("halt_flag", 32'(o_halt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      rand_instr();
      cyc("halted");
    end
    stall = 1'b1;
    cyc("halted_stall");
    stall = 1'b0;

    reset = 1'b1;
    cyc("halt_reset");
    reset = 1'b0;
    set_instr(32'h0000_1234, 32'h0, LS_WORD, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 32'h90);
    cyc("after_reset");
    chk("after_reset_count", o_retired, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
